// File: rtl/aes_round_key_gen_pkg.sv
// Shared constants, state encoding and the rcon xtime helper
// for the iterative AES-128 key expansion engine.
package aes_round_key_gen_pkg;

    localparam int BYTE = 8;
    localparam int WORD = 32;
    localparam int Nb   = 128;
    localparam int Nr   = 10;

    localparam logic [3:0] LAST_ROUND = 4'(Nr);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [BYTE-1:0] RCON_INIT  = 8'h01;
    localparam logic [BYTE-1:0] XTIME_POLY = 8'h1b;

    function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] b);
        logic [BYTE-1:0] s;
        s = {b[BYTE-2:0], 1'b0};
        if (b[BYTE-1]) begin
            s = s ^ XTIME_POLY;
        end
        return s;
    endfunction

endpackage

// File: rtl/aes_round_key_gen_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
// Four copies form SubWord in the key schedule.
module aes_sbox
    import aes_round_key_gen_pkg::*;
(
    input  logic [BYTE-1:0] in_byte,
    output logic [BYTE-1:0] out_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_round_key_gen.sv
// Iterative AES-128 key expansion: emits round keys 0..Nr,
// one per valid/ready handshake, with registered outputs.
module aes_round_key_gen
    import aes_round_key_gen_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [Nb-1:0] key_in,
    output logic [Nb-1:0] rk_out,
    output logic [3:0]    rk_round,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic          busy,
    output logic          done
);

    state_e          state_q, state_d;
    logic [Nb-1:0]   rk_q, rk_d;
    logic [3:0]      round_q, round_d;
    logic [BYTE-1:0] rcon_q, rcon_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [WORD-1:0] w0, w1, w2, w3;
    logic [WORD-1:0] rot_w, sub_w, temp;
    logic [WORD-1:0] n0, n1, n2, n3;
    logic [Nb-1:0]   next_key;

    assign w0 = rk_q[127:96];
    assign w1 = rk_q[95:64];
    assign w2 = rk_q[63:32];
    assign w3 = rk_q[31:0];

    assign rot_w = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        aes_sbox u_sbox (
            .in_byte  (rot_w[i*BYTE +: BYTE]),
            .out_byte (sub_w[i*BYTE +: BYTE])
        );
    end

    assign temp = sub_w ^ {rcon_q, 24'h0};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rk_d    = key_in;
                    round_d = 4'd0;
                    rcon_d  = RCON_INIT;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (valid_q && rk_ready) begin
                    if (round_q == LAST_ROUND) begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rk_d    = next_key;
                        round_d = round_q + 4'd1;
                        rcon_d  = xtime(rcon_q);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rk_q    <= '0;
            round_q <= 4'd0;
            rcon_q  <= RCON_INIT;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_out   = rk_q;
    assign rk_round = round_q;
    assign rk_valid = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_round_key_gen.sv
// Scoreboard bench for aes_round_key_gen: a GF(2^8) based
// reference key schedule feeds an expected-key queue.
module tb_aes_round_key_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
    logic         done;

    aes_round_key_gen dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int valid_cycles = 0;
    bit done_exp = 1'b0;

    logic [131:0] exp_q[$];
    logic [7:0]   sb[256];
    logic [127:0] mk[11];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        if (x != 8'h00) begin
            for (int b = 1; b < 256; b++) begin
                if (gf_mul(x, 8'(b)) == 8'h01) inv = 8'(b);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
             ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic check(input string name, input logic [131:0] got, input logic [131:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [131:0] e;
        if (done_exp) begin
            check("done_pulse", 132'(done), 132'd1);
            done_exp = 1'b0;
        end else if (done === 1'b1) begin
            check("spurious_done", 132'(done), 132'd0);
        end
        if (done === 1'b1) done_cnt++;
        if (rk_valid === 1'b1) valid_cycles++;
        if (rk_valid === 1'b1 && rk_ready === 1'b1 && rst === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_key", {rk_round, rk_out}, 132'd0);
            end else begin
                e = exp_q.pop_front();
                check("sb_key", {rk_round, rk_out}, e);
            end
            if (rk_round == 4'd10) done_exp = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input bit rnd);
        int n = 0;
        while (!(busy === 1'b0 && done === 1'b0) && n < 1000) begin
            if (rnd) rk_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        if (n >= 1000) check("idle_timeout", 132'(n), 132'd0);
        rk_ready = 1'b1;
    endtask

    task automatic issue(input logic [127:0] key);
        expand(key);
        for (int r = 0; r < 11; r++) exp_q.push_back({4'(r), mk[r]});
        key_in = key;
        start = 1'b1;
        tick();
        start = 1'b0;
        key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (!(rk_valid === 1'b1 && rk_round == r) && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("round_timeout", 132'(r), 132'd0);
    endtask

    task automatic run_checked(input logic [127:0] key, input bit rnd);
        int d0 = done_cnt;
        issue(key);
        wait_idle(rnd);
        check("done_count", 132'(done_cnt), 132'(d0 + 1));
        check("all_accepted", 132'(exp_q.size()), 132'd0);
    endtask

    initial begin
        int d0;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        rk_ready = 1'b1;
        repeat (3) tick();
        check("reset_outs", {rk_out, rk_round, rk_valid, busy, done}, '0);
        rst = 1'b0;
        tick();

        // FIPS-197 vector with free-running consumer
        valid_cycles = 0;
        d0 = done_cnt;
        issue(FIPS_KEY);
        check("first_valid", {3'd0, busy, rk_valid}, 5'b00011);
        wait_round(4'd0);
        check("fips_r0", 132'(rk_out), 132'(FIPS_KEY));
        wait_round(4'd1);
        check("fips_r1", 132'(rk_out), 132'h0a0fafe1788542cb123a339392a6c7605);
        wait_round(4'd2);
        check("fips_r2", 132'(rk_out), 132'h0f2c295f27a96b9435935807a7359f67f);
        wait_round(4'd10);
        check("fips_r10", 132'(rk_out), 132'h0d014f9a8c9ee2589e13f0cc8b6630ca6);
        wait_idle(1'b0);
        check("valid_cycles", 132'(valid_cycles), 132'd11);
        check("fips_done", 132'(done_cnt), 132'(d0 + 1));

        // backpressure at round 4
        issue(FIPS_KEY);
        wait_round(4'd4);
        rk_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_hold", {rk_round, rk_out}, {4'd4, mk[4]});
        end
        rk_ready = 1'b1;
        wait_idle(1'b0);
        check("bp_all", 132'(exp_q.size()), 132'd0);

        // start during EMIT must be ignored
        d0 = done_cnt;
        issue(FIPS_KEY);
        wait_round(4'd5);
        key_in = ~FIPS_KEY;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(1'b0);
        check("ign_start_done", 132'(done_cnt), 132'(d0 + 1));
        check("ign_start_all", 132'(exp_q.size()), 132'd0);

        // reset mid-expansion
        d0 = done_cnt;
        issue(FIPS_KEY);
        wait_round(4'd7);
        rst = 1'b1;
        tick();
        check("rst_mid", {rk_out, rk_round, rk_valid, busy, done}, '0);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) tick();
        check("rst_no_done", 132'(done_cnt), 132'(d0));
        issue(FIPS_KEY);
        wait_round(4'd1);
        check("rst_r1", 132'(rk_out), 132'h0a0fafe1788542cb123a339392a6c7605);
        wait_idle(1'b0);

        // all-zero key
        issue(128'h0);
        wait_round(4'd1);
        check("zero_r1", 132'(rk_out), 132'h062636363626363636263636362636363);
        wait_round(4'd10);
        check("zero_r10", 132'(rk_out), 132'h0b4ef5bcb3e92e21123e951cf6f8f188e);
        wait_idle(1'b0);

        // random keys with random consumer stalls
        for (int k = 0; k < 50; k++) begin
            run_checked({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_key_gen.md
Name: aes_round_key_gen

Overview:
Iterative AES-128 key expansion engine. It produces one 128-bit round key per handshake, for rounds 0..Nr. It feeds the add-round-key stage that consumes the mixColumns state output. Word ordering matches the state column ordering: w0 = key[127:96] aligns with column 1 at the MSBs.

Parameters:
BYTE, 8, bits per byte
WORD, 32, bits per key word / state column
Nb, 128, key and round-key width in bits
Nr, 10, number of rounds (round keys 0..Nr are emitted)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request expansion of key_in; sampled only in IDLE
key_in  input  Nb  cipher key; w0 = key_in[127:96], w3 = key_in[31:0]
rk_out  output  Nb  current round key, same word ordering as key_in
rk_round  output  4  index of round key on rk_out, 0..Nr
rk_valid  output  1  rk_out/rk_round valid
rk_ready  input  1  consumer accepts the key when rk_valid && rk_ready
busy  output  1  high while not IDLE
done  output  1  one-cycle pulse after round Nr key is accepted

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: state=IDLE; rk_out=0, rk_round=0, rk_valid=0, busy=0, done=0, internal rcon=8'h01.
- FSM states: IDLE, EMIT, DONE.
- IDLE:
  - start=1 at edge t: register key_in into rk_out, set rk_round=0 and rcon=8'h01, go to EMIT.
  - From edge t: rk_valid=1, busy=1. Latency from start to first valid key is 1 cycle.
- EMIT:
  - Hold: if rk_valid && !rk_ready, rk_out, rk_round and rcon hold stable.
  - Advance: on rk_valid && rk_ready with rk_round < Nr, register the next key and increment rk_round. rk_valid stays 1, so back-to-back keys can be accepted every cycle.
  - Next key computation:
    - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
    - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'
    - RotWord({a,b,c,d}) = {b,c,d,a}. SubWord applies the AES S-box to each byte.
  - rcon update per advance: rcon = xtime(rcon), i.e. shift left 1, XOR 8'h1b if bit 7 was set. Sequence 01,02,04,08,10,20,40,80,1b,36.
  - Last key: handshake with rk_round == Nr sets rk_valid=0 and goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. rk_out keeps the last key, but it is not valid.
- start is ignored when not in IDLE, including the DONE cycle. key_in changes after the start cycle have no effect.
- rst asserted in any state, including mid-expansion or during a stalled handshake, forces the reset values on the next edge. No done pulse is generated.
- rk_ready is ignored when rk_valid=0.
- Purely combinational path: only the next-key function. All outputs are registered.

Decomposition:
- Shared package/include holds:
  - BYTE, WORD, Nb, Nr constants
  - FSM state encoding (IDLE=2'd0, EMIT=2'd1, DONE=2'd2)
  - RCON_INIT = 8'h01 and the xtime reduction constant 8'h1b
- One sub-module, aes_sbox: 8-bit combinational S-box lookup. It is instantiated 4 times for SubWord.
- RotWord and the XOR chain stay inline.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready held 1, start pulse:
  - round 0 equals the key
  - round 1 = a0fafe1788542cb123a339392a6c7605
  - round 2 = f2c295f27a96b9435935807a7359f67f
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - done pulses 1 cycle after round 10 is accepted
  - 11 consecutive valid cycles in total
- Backpressure: same key, rk_ready low for 3 cycles at round 4 -> rk_out and rk_round=4 stable for all 3 cycles, then the sequence continues with identical keys.
- start pulsed with a different key_in during EMIT at round 5 -> ignored; remaining keys match the original key's schedule.
- rst asserted at round 7 -> next cycle rk_valid=0, busy=0, rk_out=0, no done. A new start then yields round 0 again, with rcon restarting at 01, verified by a correct round 1 key.
- All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Random rk_ready toggling over 50 random keys -> emitted keys match a reference model. Exactly Nr+1 accepted handshakes and one done per start.
